// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer RAM port plus pixel-writer handshake shared by the arbiter (master)
// and the RAM/writer side (slave).
interface vga_fb_arbiter_if #(
   parameter int AW = 17,
   parameter int DW = 12
);
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic          mem_en;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;

   modport master (
      output mem_addr, mem_we, mem_en, mem_wdata, wr_ack,
      input  mem_rdata, wr_req, wr_addr, wr_data
   );

   modport slave (
      input  mem_addr, mem_we, mem_en, mem_wdata, wr_ack,
      output mem_rdata, wr_req, wr_addr, wr_data
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scan-out prefetch and a pixel writer.
// Scan-out fetch has strict priority; the writer receives every remaining memory slot.
module vga_fb_arbiter #(
   parameter int PIX_BITS     = 3,
   parameter int PIX_PER_WORD = 4,
   parameter int DW           = PIX_BITS * PIX_PER_WORD,
   parameter int AW           = 17,
   parameter int FRAME_WORDS  = 76800
) (
   input  logic                pixelClock,
   input  logic                nReset,
   input  logic                draw,
   input  logic                v_sync_signal,
   vga_fb_arbiter_if.master    bus,
   output logic [PIX_BITS-1:0] pixel,
   output logic                underrun
);
   localparam int            PW         = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam logic [AW-1:0] FRAME_END  = AW'(FRAME_WORDS);
   localparam logic [PW-1:0] LAST_PHASE = PW'(PIX_PER_WORD - 1);

   logic [AW-1:0] fptr;
   logic [PW-1:0] phase;
   logic [DW-1:0] sr;
   logic [DW-1:0] nxt;
   logic          sr_valid;
   logic          nxt_valid;
   logic          rd_inflight;
   logic [1:0]    occ;
   logic          fetch;
   logic          write;
   logic          consume;

   // Grant is combinational and gated by reset so the RAM sees no access while nReset is low.
   always_comb begin
      occ           = 2'(sr_valid) + 2'(nxt_valid) + 2'(rd_inflight);
      fetch         = nReset && !v_sync_signal && (occ < 2'd2) && (fptr < FRAME_END);
      write         = nReset && !fetch && bus.wr_req;
      consume       = draw && (phase == LAST_PHASE);
      bus.mem_en    = fetch || write;
      bus.mem_we    = write && (bus.wr_addr < FRAME_END);
      bus.mem_addr  = fetch ? fptr : (write ? bus.wr_addr : '0);
      bus.mem_wdata = write ? bus.wr_data : '0;
      bus.wr_ack    = write;
   end

   always_ff @(posedge pixelClock or negedge nReset) begin
      if (!nReset) begin
         fptr        <= '0;
         phase       <= '0;
         sr          <= '0;
         nxt         <= '0;
         sr_valid    <= 1'b0;
         nxt_valid   <= 1'b0;
         rd_inflight <= 1'b0;
         pixel       <= '0;
         underrun    <= 1'b0;
      end else if (v_sync_signal) begin
         // A read returning now belongs to the old frame and is dropped with the buffer.
         fptr        <= '0;
         phase       <= '0;
         sr_valid    <= 1'b0;
         nxt_valid   <= 1'b0;
         rd_inflight <= 1'b0;
         pixel       <= '0;
         underrun    <= 1'b0;
      end else begin
         rd_inflight <= fetch;
         if (fetch)
            fptr <= fptr + AW'(1);

         if (draw) begin
            phase <= (phase == LAST_PHASE) ? '0 : phase + PW'(1);
            if (sr_valid) begin
               pixel <= sr[PIX_BITS-1:0];
            end else begin
               pixel    <= '0;
               underrun <= 1'b1;
            end
         end else begin
            pixel <= '0;
         end

         if (consume) begin
            if (nxt_valid) begin
               sr        <= nxt;
               sr_valid  <= 1'b1;
               nxt       <= bus.mem_rdata;
               nxt_valid <= rd_inflight;
            end else if (rd_inflight) begin
               sr       <= bus.mem_rdata;
               sr_valid <= 1'b1;
            end else begin
               sr_valid <= 1'b0;
            end
         end else begin
            if (draw && sr_valid)
               sr <= sr >> PIX_BITS;
            if (rd_inflight) begin
               if (!sr_valid) begin
                  sr       <= bus.mem_rdata;
                  sr_valid <= 1'b1;
               end else begin
                  nxt       <= bus.mem_rdata;
                  nxt_valid <= 1'b1;
               end
            end
         end
      end
   end
endmodule
